// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI3 read channel (AR/R) between the I-cache refill port,
// the D-cache refill port and the uncached load port. One transaction is in flight at a time.
// The R beats are gathered into a line buffer, and the result is returned with a 1-cycle pulse.
module axi_read_arbiter #(
    parameter int unsigned ICACHE_LINE_WORD  = 4,
    parameter int unsigned DCACHE_LINE_WORD  = 4,
    parameter int unsigned MAX_LINE_WORD     = 4,
    parameter int unsigned ICACHE_STARVE_MAX = 4,
    parameter logic [3:0]  ID_I              = 4'd0,
    parameter logic [3:0]  ID_D              = 4'd1,
    parameter logic [3:0]  ID_U              = 4'd2
) (
    input  logic                          clk,
    input  logic                          rst,

    // I-cache refill port
    input  logic                          i_rd_req,
    input  logic [31:0]                   i_rd_addr,
    output logic                          i_rd_rdy,
    output logic                          i_ret_valid,
    output logic [ICACHE_LINE_WORD*32-1:0] i_ret_data,

    // D-cache refill port
    input  logic                          d_rd_req,
    input  logic [31:0]                   d_rd_addr,
    output logic                          d_rd_rdy,
    output logic                          d_ret_valid,
    output logic [DCACHE_LINE_WORD*32-1:0] d_ret_data,

    // Uncached load port
    input  logic                          u_rd_req,
    input  logic [31:0]                   u_rd_addr,
    input  logic [2:0]                    u_rd_size,
    output logic                          u_rd_rdy,
    output logic                          u_ret_valid,
    output logic [31:0]                   u_ret_data,

    // AXI3 read address channel
    output logic [3:0]                    arid,
    output logic [31:0]                   araddr,
    output logic [3:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic [1:0]                    arburst,
    output logic                          arvalid,
    input  logic                          arready,

    // AXI3 read data channel
    input  logic [3:0]                    rid,
    input  logic [31:0]                   rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rlast,
    input  logic                          rvalid,
    output logic                          rready
);

    localparam int unsigned BEAT_W   = (MAX_LINE_WORD > 1) ? $clog2(MAX_LINE_WORD) : 1;
    localparam int unsigned STARVE_W = (ICACHE_STARVE_MAX > 0) ? $clog2(ICACHE_STARVE_MAX + 1) : 1;

    // Line-alignment masks: clear the byte-offset bits of a cache line (line sizes are 2^n words)
    localparam logic [31:0] I_MASK = ~(32'(ICACHE_LINE_WORD * 4) - 32'd1);
    localparam logic [31:0] D_MASK = ~(32'(DCACHE_LINE_WORD * 4) - 32'd1);

    localparam logic [BEAT_W-1:0]   BEAT_LAST  = BEAT_W'(MAX_LINE_WORD - 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(ICACHE_STARVE_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData,
        StRet
    } state_t;

    typedef enum logic [1:0] {
        GntNone,
        GntI,
        GntD,
        GntU
    } gnt_t;

    state_t                          r_state;
    gnt_t                            r_gnt;
    logic [STARVE_W-1:0]             r_starve_cnt;
    logic [BEAT_W-1:0]               r_beat;
    logic [31:0]                     r_buf [MAX_LINE_WORD];

    logic                            r_arvalid;
    logic [31:0]                     r_araddr;
    logic [3:0]                      r_arlen;
    logic [2:0]                      r_arsize;
    logic [3:0]                      r_arid;
    logic                            r_rready;

    logic                            r_i_ret_valid;
    logic [ICACHE_LINE_WORD*32-1:0]  r_i_ret_data;
    logic                            r_d_ret_valid;
    logic [DCACHE_LINE_WORD*32-1:0]  r_d_ret_data;
    logic                            r_u_ret_valid;
    logic [31:0]                     r_u_ret_data;

    gnt_t                            w_win;
    logic [31:0]                     w_words [MAX_LINE_WORD];
    logic [ICACHE_LINE_WORD*32-1:0]  w_i_line;
    logic [DCACHE_LINE_WORD*32-1:0]  w_d_line;

    // Responses are strictly in order with one transaction outstanding, so rid/rresp carry no info
    logic w_unused;
    assign w_unused = ^{rid, rresp};

    // Pick the winner in IDLE: starved I-cache first, otherwise U > D > I
    always_comb begin
        w_win = GntNone;
        if ((r_state == StIdle) && !rst) begin
            if (i_rd_req && (r_starve_cnt == STARVE_LIM)) begin
                w_win = GntI;
            end else if (u_rd_req) begin
                w_win = GntU;
            end else if (d_rd_req) begin
                w_win = GntD;
            end else if (i_rd_req) begin
                w_win = GntI;
            end
        end
    end

    // Buffer contents as they will be after the beat currently on the bus is written
    always_comb begin
        for (int k = 0; k < int'(MAX_LINE_WORD); k++) begin
            w_words[k] = (BEAT_W'(k) == r_beat) ? rdata : r_buf[k];
        end
    end

    // Pack the merged buffer into the per-port line layouts (word k at bits [32k +: 32])
    always_comb begin
        w_i_line = '0;
        w_d_line = '0;
        for (int k = 0; k < int'(ICACHE_LINE_WORD); k++) begin
            w_i_line[32*k +: 32] = w_words[k];
        end
        for (int k = 0; k < int'(DCACHE_LINE_WORD); k++) begin
            w_d_line[32*k +: 32] = w_words[k];
        end
    end

    // Main FSM: grant latch, AR issue, beat collection, one-cycle return pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_gnt         <= GntNone;
            r_starve_cnt  <= '0;
            r_beat        <= '0;
            for (int k = 0; k < int'(MAX_LINE_WORD); k++) begin
                r_buf[k] <= '0;
            end
            r_arvalid     <= 1'b0;
            r_araddr      <= '0;
            r_arlen       <= '0;
            r_arsize      <= '0;
            r_arid        <= '0;
            r_rready      <= 1'b0;
            r_i_ret_valid <= 1'b0;
            r_i_ret_data  <= '0;
            r_d_ret_valid <= 1'b0;
            r_d_ret_data  <= '0;
            r_u_ret_valid <= 1'b0;
            r_u_ret_data  <= '0;
        end else begin
            r_i_ret_valid <= 1'b0;
            r_d_ret_valid <= 1'b0;
            r_u_ret_valid <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (!i_rd_req || (w_win == GntI)) begin
                        r_starve_cnt <= '0;
                    end else if ((w_win != GntNone) && (r_starve_cnt != STARVE_LIM)) begin
                        r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
                    end

                    if (w_win != GntNone) begin
                        r_gnt     <= w_win;
                        r_arvalid <= 1'b1;
                        r_state   <= StAddr;
                        unique case (w_win)
                            GntI: begin
                                r_arid   <= ID_I;
                                r_araddr <= i_rd_addr & I_MASK;
                                r_arlen  <= 4'(ICACHE_LINE_WORD - 1);
                                r_arsize <= 3'b010;
                            end
                            GntD: begin
                                r_arid   <= ID_D;
                                r_araddr <= d_rd_addr & D_MASK;
                                r_arlen  <= 4'(DCACHE_LINE_WORD - 1);
                                r_arsize <= 3'b010;
                            end
                            GntU: begin
                                r_arid   <= ID_U;
                                r_araddr <= u_rd_addr;
                                r_arlen  <= 4'd0;
                                r_arsize <= u_rd_size;
                            end
                            default: begin
                                r_arid <= r_arid;
                            end
                        endcase
                    end
                end

                StAddr: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_beat    <= '0;
                        r_state   <= StData;
                    end
                end

                StData: begin
                    if (rvalid) begin
                        r_buf[r_beat] <= rdata;
                        if (r_beat != BEAT_LAST) begin
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                        if (rlast) begin
                            r_rready <= 1'b0;
                            r_state  <= StRet;
                            unique case (r_gnt)
                                GntI: begin
                                    r_i_ret_valid <= 1'b1;
                                    r_i_ret_data  <= w_i_line;
                                end
                                GntD: begin
                                    r_d_ret_valid <= 1'b1;
                                    r_d_ret_data  <= w_d_line;
                                end
                                GntU: begin
                                    r_u_ret_valid <= 1'b1;
                                    r_u_ret_data  <= w_words[0];
                                end
                                default: begin
                                    r_u_ret_valid <= 1'b0;
                                end
                            endcase
                        end
                    end
                end

                StRet: begin
                    r_state <= StIdle;
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign i_rd_rdy    = (w_win == GntI);
    assign d_rd_rdy    = (w_win == GntD);
    assign u_rd_rdy    = (w_win == GntU);

    assign i_ret_valid = r_i_ret_valid;
    assign i_ret_data  = r_i_ret_data;
    assign d_ret_valid = r_d_ret_valid;
    assign d_ret_data  = r_d_ret_data;
    assign u_ret_valid = r_u_ret_valid;
    assign u_ret_data  = r_u_ret_data;

    assign arid        = r_arid;
    assign araddr      = r_araddr;
    assign arlen       = r_arlen;
    assign arsize      = r_arsize;
    assign arburst     = 2'b01;
    assign arvalid     = r_arvalid;
    assign rready      = r_rready;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Testbench for axi_read_arbiter: directed stimulus with a queue-based scoreboard.
module tb_axi_read_arbiter;

    logic         clk;
    logic         rst;
    logic         i_rd_req, d_rd_req, u_rd_req;
    logic [31:0]  i_rd_addr, d_rd_addr, u_rd_addr;
    logic [2:0]   u_rd_size;
    logic         i_rd_rdy, d_rd_rdy, u_rd_rdy;
    logic         i_ret_valid, d_ret_valid, u_ret_valid;
    logic [127:0] i_ret_data, d_ret_data;
    logic [31:0]  u_ret_data;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [3:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid, arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;

    axi_read_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .i_rd_req    (i_rd_req),
        .i_rd_addr   (i_rd_addr),
        .i_rd_rdy    (i_rd_rdy),
        .i_ret_valid (i_ret_valid),
        .i_ret_data  (i_ret_data),
        .d_rd_req    (d_rd_req),
        .d_rd_addr   (d_rd_addr),
        .d_rd_rdy    (d_rd_rdy),
        .d_ret_valid (d_ret_valid),
        .d_ret_data  (d_ret_data),
        .u_rd_req    (u_rd_req),
        .u_rd_addr   (u_rd_addr),
        .u_rd_size   (u_rd_size),
        .u_rd_rdy    (u_rd_rdy),
        .u_ret_valid (u_ret_valid),
        .u_ret_data  (u_ret_data),
        .arid        (arid),
        .araddr      (araddr),
        .arlen       (arlen),
        .arsize      (arsize),
        .arburst     (arburst),
        .arvalid     (arvalid),
        .arready     (arready),
        .rid         (rid),
        .rdata       (rdata),
        .rresp       (rresp),
        .rlast       (rlast),
        .rvalid      (rvalid),
        .rready      (rready)
    );

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected AR: {arid, araddr, arlen, arsize}; expected return: {port, data} with I=1, D=2, U=3
    typedef logic [42:0]  ar_t;
    typedef logic [129:0] ret_t;
    ar_t  exp_ar[$];
    ret_t exp_ret[$];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] line4(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents an AR handshake or a return pulse
    task automatic monitor();
        ar_t        e_ar;
        ret_t       e_ret;
        logic [2:0] rv;
        logic [2:0] rdy;
        ret_t       a_ret;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (arvalid && arready) begin
                    if (exp_ar.size() == 0) begin
                        check("ar_unexpected", {arid, araddr, arlen, arsize}, 0);
                    end else begin
                        e_ar = exp_ar.pop_front();
                        check("ar_fields", {arid, araddr, arlen, arsize}, e_ar);
                    end
                end
                rv = {i_ret_valid, d_ret_valid, u_ret_valid};
                if (|rv) begin
                    check("ret_onehot", $countones(rv), 1);
                    if (i_ret_valid)      a_ret = {2'd1, i_ret_data};
                    else if (d_ret_valid) a_ret = {2'd2, d_ret_data};
                    else                  a_ret = {2'd3, 96'd0, u_ret_data};
                    if (exp_ret.size() == 0) begin
                        check("ret_unexpected", rv, 3'b000);
                    end else begin
                        e_ret = exp_ret.pop_front();
                        check("ret_data", a_ret, e_ret);
                    end
                end
                rdy = {i_rd_rdy, d_rd_rdy, u_rd_rdy};
                if (|rdy) begin
                    check("rdy_onehot", $countones(rdy), 1);
                    check("rdy_only_idle", {arvalid, rready}, 2'b00);
                end
            end
        end
    endtask

    // Wait for the expected AR, optionally stall arready, then complete the handshake
    task automatic ar_phase(input logic [3:0] eid, input logic [31:0] eaddr,
                            input logic [3:0] elen, input logic [2:0] esize,
                            input int delay, input bit drop);
        bit seen;
        seen = 1'b0;
        exp_ar.push_back({eid, eaddr, elen, esize});
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (arvalid) seen = 1'b1;
        end
        check("ar_wait", seen, 1);
        if (!seen) return;
        @(posedge clk); #1;
        if (drop) begin
            case (eid)
                4'd0:    i_rd_req = 1'b0;
                4'd1:    d_rd_req = 1'b0;
                default: u_rd_req = 1'b0;
            endcase
        end
        for (int c = 0; c < delay; c++) begin
            @(negedge clk);
            check("ar_hold", {arvalid, arid, araddr, arlen, arsize},
                  {1'b1, eid, eaddr, elen, esize});
            @(posedge clk); #1;
        end
        arready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        arready = 1'b0;
    endtask

    // Drive n beats (base+k), with a one-cycle gap before beat k when gap_mask[k] is set
    task automatic r_phase(input int n, input logic [31:0] base, input logic [3:0] gap_mask,
                           input logic [1:0] port, input logic [127:0] edata);
        logic [2:0] pulse;
        exp_ret.push_back({port, edata});
        for (int b = 0; b < n; b++) begin
            if (gap_mask[b]) begin
                rvalid = 1'b0;
                @(posedge clk); #1;
            end
            rvalid = 1'b1;
            rdata  = base + 32'(b);
            rlast  = (b == n - 1);
            @(negedge clk);
            check("beat_rready", rready, 1);
            @(posedge clk); #1;
            rvalid = 1'b0;
            rlast  = 1'b0;
            rdata  = 32'd0;
        end
        case (port)
            2'd1:    pulse = 3'b100;
            2'd2:    pulse = 3'b010;
            default: pulse = 3'b001;
        endcase
        @(negedge clk);
        check("ret_latency", {i_ret_valid, d_ret_valid, u_ret_valid}, pulse);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        i_rd_req = 1'b0; d_rd_req = 1'b0; u_rd_req = 1'b0;
        i_rd_addr = 32'd0; d_rd_addr = 32'd0; u_rd_addr = 32'd0; u_rd_size = 3'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0; rvalid = 1'b0;

        fork
            monitor();
            begin
                #100000;
                $display("FAIL watchdog: time limit reached before end of test");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ar", {arvalid, arid, araddr, arlen, arsize}, 0);
        check("rst_arburst", arburst, 2'b01);
        check("rst_rready", rready, 0);
        check("rst_rdy", {i_rd_rdy, d_rd_rdy, u_rd_rdy}, 0);
        check("rst_ret_valid", {i_ret_valid, d_ret_valid, u_ret_valid}, 0);
        check("rst_i_ret_data", i_ret_data, 0);
        check("rst_du_ret_data", {d_ret_data, u_ret_data}, 0);

        // Single I-cache refill
        @(posedge clk); #1;
        i_rd_addr = 32'h1FC0_0014;
        i_rd_req  = 1'b1;
        @(negedge clk);
        check("i_rdy_pulse", {i_rd_rdy, d_rd_rdy, u_rd_rdy}, 3'b100);
        ar_phase(4'd0, 32'h1FC0_0010, 4'd3, 3'd2, 0, 1'b1);
        r_phase(4, 32'hA0, 4'b0000, 2'd1, 128'h000000A3_000000A2_000000A1_000000A0);
        @(negedge clk);
        check("i_ret_hold", {i_ret_valid, i_ret_data},
              {1'b0, 128'h000000A3_000000A2_000000A1_000000A0});

        // Uncached load
        @(posedge clk); #1;
        u_rd_addr = 32'hBFAF_8002;
        u_rd_size = 3'd1;
        u_rd_req  = 1'b1;
        ar_phase(4'd2, 32'hBFAF_8002, 4'd0, 3'd1, 0, 1'b1);
        r_phase(1, 32'h1234, 4'b0000, 2'd3, 128'h1234);

        // Simultaneous requests: U, then D, then I
        i_rd_addr = 32'h0000_1238;
        d_rd_addr = 32'h8000_0044;
        u_rd_addr = 32'hBFD0_0004;
        u_rd_size = 3'd2;
        i_rd_req  = 1'b1;
        d_rd_req  = 1'b1;
        u_rd_req  = 1'b1;
        ar_phase(4'd2, 32'hBFD0_0004, 4'd0, 3'd2, 0, 1'b1);
        r_phase(1, 32'h77, 4'b0000, 2'd3, 128'h77);
        ar_phase(4'd1, 32'h8000_0040, 4'd3, 3'd2, 0, 1'b1);
        r_phase(4, 32'hD0, 4'b0000, 2'd2, line4(32'hD0));
        ar_phase(4'd0, 32'h0000_1230, 4'd3, 3'd2, 0, 1'b1);
        r_phase(4, 32'hB0, 4'b0000, 2'd1, line4(32'hB0));

        // Starvation: four D wins, then I forced, then D again (counter back at 0)
        i_rd_addr = 32'h2000_0004;
        d_rd_addr = 32'h3000_001C;
        i_rd_req  = 1'b1;
        d_rd_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ar_phase(4'd1, 32'h3000_0010, 4'd3, 3'd2, 0, 1'b0);
            r_phase(4, 32'h100 * 32'(k + 1), 4'b0000, 2'd2, line4(32'h100 * 32'(k + 1)));
        end
        ar_phase(4'd0, 32'h2000_0000, 4'd3, 3'd2, 0, 1'b0);
        r_phase(4, 32'hC0, 4'b0000, 2'd1, line4(32'hC0));
        ar_phase(4'd1, 32'h3000_0010, 4'd3, 3'd2, 0, 1'b1);
        r_phase(4, 32'h600, 4'b0000, 2'd2, line4(32'h600));
        ar_phase(4'd0, 32'h2000_0000, 4'd3, 3'd2, 0, 1'b1);
        r_phase(4, 32'hC8, 4'b0000, 2'd1, line4(32'hC8));

        // Back-pressure on AR and gaps between R beats
        d_rd_addr = 32'h4000_002C;
        d_rd_req  = 1'b1;
        ar_phase(4'd1, 32'h4000_0020, 4'd3, 3'd2, 5, 1'b1);
        r_phase(4, 32'h5500_0000, 4'b1010, 2'd2, line4(32'h5500_0000));

        // Asynchronous reset in DATA after two beats
        d_rd_addr = 32'h5000_0000;
        d_rd_req  = 1'b1;
        ar_phase(4'd1, 32'h5000_0000, 4'd3, 3'd2, 0, 1'b1);
        for (int b = 0; b < 2; b++) begin
            rvalid = 1'b1;
            rdata  = 32'hEE00 + 32'(b);
            rlast  = 1'b0;
            @(posedge clk); #1;
            rvalid = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check("rst_mid_axi", {arvalid, rready, i_ret_valid, d_ret_valid, u_ret_valid}, 0);
        check("rst_mid_ret_data", d_ret_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_quiet", {arvalid, rready, i_ret_valid, d_ret_valid, u_ret_valid}, 0);
        d_rd_addr = 32'h5000_0048;
        d_rd_req  = 1'b1;
        ar_phase(4'd1, 32'h5000_0040, 4'd3, 3'd2, 0, 1'b1);
        r_phase(4, 32'hE0, 4'b0000, 2'd2, line4(32'hE0));

        repeat (2) @(posedge clk);
        check("ar_queue_empty", exp_ar.size(), 0);
        check("ret_queue_empty", exp_ret.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
